voice_allocator: RTL and testbench

VOICE_ALLOCATOR -- requirements
Module: voice_allocator

---
 rtl/voice_allocator.sv | 148 ++++++++++++++
 tb/tb_voice_allocator.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/voice_allocator.sv
// Voice allocator: keeps a table of NBANKS held MIDI notes and streams one slot per
// sample-enable cycle to a time-multiplexed phase bank.
module voice_allocator #(
  parameter int NBANKS = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_en,
  input  logic       i_ev_valid,
  input  logic       i_ev_on,
  input  logic [6:0] i_ev_note,
  input  logic       i_panic,
  output logic       o_ev_ready,
  output logic [6:0] o_midi,
  output logic [3:0] o_slot,
  output logic       o_frame_start,
  output logic [3:0] o_active,
  output logic       o_overflow
);

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_UPDATE = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [6:0]  table_q [NBANKS];
  logic [6:0]  table_d [NBANKS];
  logic [3:0]  cnt_q, cnt_d;
  logic        ev_on_q;
  logic [6:0]  ev_note_q;
  logic [6:0]  midi_q;
  logic [3:0]  slot_q;
  logic        frame_q;
  logic [3:0]  active_q, active_d;
  logic        overflow_d;

  logic [NBANKS-1:0] free_vec;
  logic [NBANKS-1:0] match_vec;
  logic [NBANKS-1:0] lowest_free;
  logic              accept;

  genvar gi;
  generate
    for (gi = 0; gi < NBANKS; gi++) begin : g_scan
      assign free_vec[gi]  = (table_q[gi] == 7'd0);
      assign match_vec[gi] = (table_q[gi] == ev_note_q);
    end
  endgenerate

  // One-hot of the lowest-index free entry (isolate least significant set bit).
  assign lowest_free = free_vec & ~(free_vec - NBANKS'(1));

  assign o_ev_ready = (state_q == S_IDLE) && !rst;
  assign accept     = i_ev_valid && o_ev_ready && clk_en;
  assign cnt_d      = (cnt_q == 4'(NBANKS - 1)) ? 4'd0 : cnt_q + 4'd1;

  always_comb begin
    state_d    = state_q;
    overflow_d = 1'b0;
    for (int i = 0; i < NBANKS; i++) begin
      table_d[i] = table_q[i];
    end
    if (clk_en && !rst) begin
      if (i_panic) begin
        state_d = S_IDLE;
        for (int i = 0; i < NBANKS; i++) begin
          table_d[i] = 7'd0;
        end
      end else begin
        case (state_q)
          S_IDLE: begin
            if (i_ev_valid) state_d = S_UPDATE;
          end
          S_UPDATE: begin
            state_d = S_IDLE;
            // Note 0 is the silent marker, so such events are consumed with no effect.
            if (ev_note_q != 7'd0) begin
              if (ev_on_q) begin
                if (match_vec == '0) begin
                  if (free_vec == '0) begin
                    overflow_d = 1'b1;
                  end else begin
                    for (int i = 0; i < NBANKS; i++) begin
                      if (lowest_free[i]) table_d[i] = ev_note_q;
                    end
                  end
                end
              end else begin
                for (int i = 0; i < NBANKS; i++) begin
                  if (match_vec[i]) table_d[i] = 7'd0;
                end
              end
            end
          end
          default: state_d = S_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    active_d = 4'd0;
    for (int i = 0; i < NBANKS; i++) begin
      active_d = active_d + 4'(table_q[i] != 7'd0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      ev_on_q   <= 1'b0;
      ev_note_q <= 7'd0;
      midi_q    <= 7'd0;
      slot_q    <= 4'd0;
      frame_q   <= 1'b1;
      active_q  <= 4'd0;
      for (int i = 0; i < NBANKS; i++) begin
        table_q[i] <= 7'd0;
      end
    end else begin
      state_q <= state_d;
      for (int i = 0; i < NBANKS; i++) begin
        table_q[i] <= table_d[i];
      end
      if (accept && !i_panic) begin
        ev_on_q   <= i_ev_on;
        ev_note_q <= i_ev_note;
      end
      // Reading table_q here returns the pre-write value when a write hits the same slot.
      if (clk_en) begin
        cnt_q    <= cnt_d;
        midi_q   <= table_q[cnt_q];
        slot_q   <= cnt_q;
        frame_q  <= (cnt_q == 4'd0);
        active_q <= active_d;
      end
    end
  end

  assign o_midi        = midi_q;
  assign o_slot        = slot_q;
  assign o_frame_start = frame_q;
  assign o_active      = active_q;
  assign o_overflow    = overflow_d;

endmodule

// File: tb/tb_voice_allocator.sv
// Directed bench for voice_allocator: slot streaming, allocation, overflow, note-off,
// panic, clock-enable gating and reset in the middle of an update.
module tb_voice_allocator;

  logic       clk = 1'b0;
  logic       rst;
  logic       clk_en;
  logic       i_ev_valid;
  logic       i_ev_on;
  logic [6:0] i_ev_note;
  logic       i_panic;
  logic       o_ev_ready;
  logic [6:0] o_midi;
  logic [3:0] o_slot;
  logic       o_frame_start;
  logic [3:0] o_active;
  logic       o_overflow;

  int n_tests = 0;
  int n_fail  = 0;

  logic [6:0]      got [10];
  logic [9:0][6:0] exp_tab;
  logic            ovf;
  logic [3:0]      s_prev;
  logic [6:0]      m_prev;
  logic [3:0]      a_prev;

  always #5 clk = ~clk;

  voice_allocator #(.NBANKS(10)) dut (
    .clk           (clk),
    .rst           (rst),
    .clk_en        (clk_en),
    .i_ev_valid    (i_ev_valid),
    .i_ev_on       (i_ev_on),
    .i_ev_note     (i_ev_note),
    .i_panic       (i_panic),
    .o_ev_ready    (o_ev_ready),
    .o_midi        (o_midi),
    .o_slot        (o_slot),
    .o_frame_start (o_frame_start),
    .o_active      (o_active),
    .o_overflow    (o_overflow)
  );

  task automatic check(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
    n_tests++;
    if (got_v !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got_v, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic dump_pass();
    for (int i = 0; i < 10; i++) got[i] = 7'h7f;
    for (int i = 0; i < 10; i++) begin
      step();
      if (o_slot < 4'd10) got[o_slot] = o_midi;
    end
  endtask

  task automatic check_table(input string tag, input logic [3:0] act);
    dump_pass();
    for (int i = 0; i < 10; i++) begin
      check($sformatf("%s_slot%0d", tag, i), got[i], exp_tab[i]);
    end
    check($sformatf("%s_active", tag), o_active, act);
    $display("[TB] %s: table pass checked, active=%0d", tag, o_active);
  endtask

  task automatic send_ev(input logic on, input logic [6:0] note, output logic ovf_o);
    int t = 0;
    while (!o_ev_ready && t < 20) begin
      step();
      t++;
    end
    check("ready_wait", o_ev_ready, 1);
    i_ev_valid = 1'b1;
    i_ev_on    = on;
    i_ev_note  = note;
    step();
    i_ev_valid = 1'b0;
    check("ready_low_update", o_ev_ready, 0);
    ovf_o = o_overflow;
    step();
    check("ready_back", o_ev_ready, 1);
    check("ovf_cleared", o_overflow, 0);
    $display("[TB] event on=%0d note=%0d overflow=%0d", on, note, ovf_o);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; clk_en = 1'b0; i_ev_valid = 1'b0; i_ev_on = 1'b0;
    i_ev_note = 7'd0; i_panic = 1'b0;
    step();
    step();
    check("rst_midi", o_midi, 0);
    check("rst_slot", o_slot, 0);
    check("rst_frame", o_frame_start, 1);
    check("rst_active", o_active, 0);
    check("rst_ovf", o_overflow, 0);
    check("rst_ready", o_ev_ready, 0);
    rst = 1'b0;
    #1;
    check("ready_after_rst", o_ev_ready, 1);

    // Free-running slot stream with an empty table.
    clk_en = 1'b1;
    for (int i = 0; i < 11; i++) begin
      step();
      check($sformatf("s32_slot%0d", i), o_slot, i % 10);
      check($sformatf("s32_frame%0d", i), o_frame_start, (i % 10) == 0);
      check($sformatf("s32_midi%0d", i), o_midi, 0);
      check($sformatf("s32_active%0d", i), o_active, 0);
      $display("[TB] idle stream cycle %0d slot=%0d frame=%0d", i, o_slot, o_frame_start);
    end

    // Two note-ons fill slots 0 and 1.
    send_ev(1'b1, 7'd60, ovf);
    send_ev(1'b1, 7'd64, ovf);
    exp_tab = '0; exp_tab[0] = 7'd60; exp_tab[1] = 7'd64;
    check_table("s33", 4'd2);

    // Fill the remaining slots, then one more note-on overflows.
    for (int k = 0; k < 8; k++) begin
      send_ev(1'b1, 7'(40 + k), ovf);
      exp_tab[2 + k] = 7'(40 + k);
    end
    check("s34_no_ovf_last_fill", ovf, 0);
    send_ev(1'b1, 7'd72, ovf);
    check("s34_ovf", ovf, 1);
    check_table("s34", 4'd10);

    // Panic clears the full table.
    i_panic = 1'b1;
    step();
    i_panic = 1'b0;
    exp_tab = '0;
    check_table("panic", 4'd0);

    // Note-off frees slot 0 for the next note-on; absent note-off and note 0 do nothing.
    send_ev(1'b1, 7'd60, ovf);
    send_ev(1'b1, 7'd64, ovf);
    send_ev(1'b0, 7'd60, ovf);
    send_ev(1'b1, 7'd67, ovf);
    exp_tab = '0; exp_tab[0] = 7'd67; exp_tab[1] = 7'd64;
    check_table("s35", 4'd2);
    send_ev(1'b0, 7'd99, ovf);
    check_table("s35_off_absent", 4'd2);
    send_ev(1'b1, 7'd0, ovf);
    check_table("s35_note0", 4'd2);

    // Panic wins over an event offered in the same cycle.
    check("s36_ready_pre", o_ev_ready, 1);
    i_ev_valid = 1'b1; i_ev_on = 1'b1; i_ev_note = 7'd60; i_panic = 1'b1;
    step();
    i_ev_valid = 1'b0; i_panic = 1'b0;
    check("s36_ready_idle", o_ev_ready, 1);
    exp_tab = '0;
    check_table("s36_panic", 4'd0);
    send_ev(1'b1, 7'd64, ovf);
    send_ev(1'b1, 7'd64, ovf);
    exp_tab = '0; exp_tab[0] = 7'd64;
    check_table("s36_dup", 4'd1);

    // Clock-enable gating with the event held valid.
    send_ev(1'b1, 7'd50, ovf);
    send_ev(1'b0, 7'd50, ovf);
    clk_en = 1'b0;
    i_ev_valid = 1'b1; i_ev_on = 1'b1; i_ev_note = 7'd50;
    s_prev = o_slot; m_prev = o_midi;
    step();
    check("s37_no_accept_en0", o_ev_ready, 1);
    check("s37_frozen_slot_a", o_slot, s_prev);
    check("s37_frozen_midi_a", o_midi, m_prev);
    clk_en = 1'b1;
    step();
    check("s37_accept_en1", o_ev_ready, 0);
    check("s37_slot_adv", o_slot, (s_prev + 4'd1) % 10);
    s_prev = o_slot; m_prev = o_midi; a_prev = o_active;
    clk_en = 1'b0;
    step();
    check("s37_update_held", o_ev_ready, 0);
    check("s37_frozen_slot_b", o_slot, s_prev);
    check("s37_frozen_midi_b", o_midi, m_prev);
    check("s37_frozen_active_b", o_active, a_prev);
    clk_en = 1'b1;
    i_ev_valid = 1'b0;
    step();
    check("s37_update_done", o_ev_ready, 1);
    check("s37_slot_adv2", o_slot, (s_prev + 4'd1) % 10);
    exp_tab = '0; exp_tab[0] = 7'd64; exp_tab[1] = 7'd50;
    check_table("s37_en", 4'd2);

    // Reset during UPDATE discards the pending event.
    i_ev_valid = 1'b1; i_ev_on = 1'b1; i_ev_note = 7'd70;
    step();
    i_ev_valid = 1'b0;
    check("s37_rst_accept", o_ev_ready, 0);
    rst = 1'b1;
    step();
    check("s37_rst_midi", o_midi, 0);
    check("s37_rst_slot", o_slot, 0);
    check("s37_rst_frame", o_frame_start, 1);
    check("s37_rst_active", o_active, 0);
    check("s37_rst_ovf", o_overflow, 0);
    check("s37_rst_ready", o_ev_ready, 0);
    rst = 1'b0;
    step();
    check("s37_first_slot", o_slot, 0);
    check("s37_first_frame", o_frame_start, 1);
    exp_tab = '0;
    check_table("s37_rst", 4'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
